// File: rtl/serial_to_parallel_aligner.sv
// serial_to_parallel_aligner
// Receive-side serial-to-parallel converter on the clk16f bit clock.
// Hunts for the COM symbol in the serial stream (MSB first). It locks byte
// alignment after COM_COUNT consecutive aligned COMs. Once locked it emits
// one byte per WIDTH cycles, with a one-cycle valid strobe for non-COM bytes.
// Optional feature macro: SP_RESYNC_EN. When defined, the link drops back to
// SEARCH after MAX_GAP consecutive non-COM bytes. When undefined, ACTIVE is
// sticky until reset.
module serial_to_parallel_aligner #(
  parameter int unsigned       WIDTH      = 8,
  parameter logic [WIDTH-1:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned       COM_COUNT  = 4,
  parameter int unsigned       MAX_GAP    = 64
) (
  input  logic             clk16f,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  // Reject out-of-range configurations at elaboration time.
  if (COM_COUNT < 2 || COM_COUNT > 15) begin : g_bad_com_count
    $error("COM_COUNT must be in 2..15");
  end
  if (MAX_GAP < 1 || MAX_GAP > 255) begin : g_bad_max_gap
    $error("MAX_GAP must be in 1..255");
  end

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-2:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [BW-1:0]    bit_cnt_q;
  logic [3:0]       com_cnt_q;
  logic [WIDTH-1:0] dout_q;
  logic             valid_q;
  logic             active_q;
  logic             is_com;
  logic             byte_edge;
`ifdef SP_RESYNC_EN
  localparam logic [7:0] GAP_TARGET = 8'(MAX_GAP);
  logic [7:0]       gap_cnt_q;
`endif

  // Current window: the shift register plus the bit being sampled this edge.
  always_comb begin
    sr_d      = {sr_q, data_in};
    is_com    = (sr_d == COM_SYMBOL);
    byte_edge = (bit_cnt_q == LAST_BIT);
  end

  // Alignment FSM with registered outputs.
  always_ff @(posedge clk16f) begin
    if (!reset_L) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      active_q  <= 1'b0;
`ifdef SP_RESYNC_EN
      gap_cnt_q <= '0;
`endif
    end else begin
      sr_q    <= sr_d[WIDTH-2:0];
      valid_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (is_com) begin
            bit_cnt_q <= '0;
            com_cnt_q <= 4'd1;
            state_q   <= ALIGN;
          end
        end
        ALIGN: begin
          bit_cnt_q <= byte_edge ? '0 : bit_cnt_q + BW'(1);
          if (byte_edge) begin
            if (is_com && (com_cnt_q + 4'd1 == COM_TARGET)) begin
              com_cnt_q <= COM_TARGET;
              active_q  <= 1'b1;
              state_q   <= ACTIVE;
`ifdef SP_RESYNC_EN
              gap_cnt_q <= '0;
`endif
            end else if (is_com) begin
              if (com_cnt_q < COM_TARGET) com_cnt_q <= com_cnt_q + 4'd1;
            end else begin
              com_cnt_q <= '0;
              state_q   <= SEARCH;
            end
          end
        end
        ACTIVE: begin
          // Alignment is frozen here. A COM pattern straddling byte edges is
          // never examined, because only byte-edge windows are looked at.
          bit_cnt_q <= byte_edge ? '0 : bit_cnt_q + BW'(1);
          if (byte_edge) begin
`ifdef SP_RESYNC_EN
            if (!is_com && (gap_cnt_q + 8'd1 == GAP_TARGET)) begin
              gap_cnt_q <= GAP_TARGET;
              com_cnt_q <= '0;
              active_q  <= 1'b0;
              state_q   <= SEARCH;
            end else begin
              gap_cnt_q <= is_com ? '0 : gap_cnt_q + 8'd1;
              dout_q    <= sr_d;
              valid_q   <= !is_com;
            end
`else
            dout_q  <= sr_d;
            valid_q <= !is_com;
`endif
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign data_out  = dout_q;
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule
